sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM CPU port (oe/we/addr/din/dout, one command per ce_ref slot) between two requesters:
  - the motherboard CPU port, which has fixed priority;
  - a DMA/loader port used for snapshot and tape loading and for MF2 RAM save/restore.
- Sits between the motherboard/boot mux and the sdram controller.
- Sequences one access per slot, returns read data with a completion pulse, and guarantees the DMA port cannot be starved.

Parameters:
- AW, 23, address width (word = byte address into SDRAM bank).
- LAT, 6, clk_sys cycles from command issue to valid mem_dout (must be 2..15).
- STARVE, 4, max consecutive CPU grants while DMA pending before DMA is forced (1..15).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- ce_ref  in  1  slot strobe (one clk_sys pulse per SDRAM slot)
- cpu_rd  in  1  CPU read request, level
- cpu_wr  in  1  CPU write request, level
- cpu_addr  in  AW  CPU address
- cpu_din  in  8  CPU write data
- cpu_q  out  8  CPU read data, registered
- cpu_ack  out  1  one-cycle pulse, CPU access complete
- dma_req  in  1  DMA request, level, held with addr/we/din until dma_ack
- dma_we  in  1  DMA write when 1, read when 0
- dma_addr  in  AW  DMA address
- dma_din  in  8  DMA write data
- dma_q  out  8  DMA read data, registered
- dma_ack  out  1  one-cycle pulse, DMA access complete
- mem_oe  out  1  SDRAM read enable
- mem_we  out  1  SDRAM write enable
- mem_addr  out  AW  SDRAM address
- mem_din  out  8  SDRAM write data
- mem_dout  in  8  SDRAM read data
- busy  out  1  1 while state != IDLE

Behaviour:
- Reset values:
  - Outputs: mem_oe=0, mem_we=0, mem_addr=0, mem_din=0, cpu_q=0, dma_q=0, cpu_ack=0, dma_ack=0, busy=0.
  - Internal: state=IDLE, starve_cnt=0, lat_cnt=0.
- Reset mid-transaction aborts at once: no ack is emitted and commands drop in the same cycle reset is sampled.
- States:
  - IDLE: waits for ce_ref=1.
    - On ce_ref, grant is decided from the inputs sampled that cycle.
    - Grant CPU if (cpu_rd|cpu_wr) and not (dma_req & starve_cnt==STARVE).
    - Otherwise grant DMA if dma_req.
    - Otherwise stay in IDLE.
  - ISSUE:
    - Entered the cycle after the grant.
    - mem_addr/mem_din are latched from the granted port.
    - mem_we=1 for a write, else mem_oe=1.
    - CPU with cpu_rd and cpu_wr both high is treated as a write.
    - Commands stay asserted until the next ce_ref (the sdram samples them on clkref), then drop; the state moves to WAIT.
  - WAIT: lat_cnt counts clk_sys cycles from ISSUE entry. When lat_cnt==LAT-1, move to DONE.
  - DONE (1 cycle):
    - For a read, mem_dout is captured into cpu_q or dma_q.
    - The matching ack pulses high for exactly this cycle.
    - The next state is IDLE.
    - A grant can occur on the first ce_ref after DONE; it is never decided in DONE itself.
- Starvation counter:
  - Increments, saturating at STARVE, on each CPU grant made while dma_req=1.
  - Clears on every DMA grant.
  - Clears when a grant is made with dma_req=0.
- Write latency: writes still run the full WAIT/DONE sequence so ack timing is identical for read and write. The q registers are unchanged on writes.
- Requester rules:
  - CPU request withdrawn after grant: the access completes and cpu_ack still pulses.
  - dma_req dropped before dma_ack: the access completes and dma_ack still pulses.
  - Requester inputs are not re-sampled after grant.
- Address handling: AW-bit pass-through with no arithmetic and no wrap logic.
- Worst-case CPU wait: one in-flight DMA access plus one slot.

Test Plan:
- CPU read only, addr 0x000123, mem_dout=0x5A, LAT=6:
  - mem_oe high from the cycle after ce_ref until the next ce_ref;
  - cpu_ack pulses 6 cycles after ISSUE entry with cpu_q=0x5A;
  - dma_ack stays 0.
- DMA write, addr 0x7FFFFF, din 0xC3, CPU idle: mem_we=1, mem_addr=0x7FFFFF, mem_din=0xC3; dma_ack pulses once; dma_q unchanged at 0.
- CPU and DMA both requesting continuously with STARVE=4: grant order is CPU,CPU,CPU,CPU,DMA, repeating; no ack is ever lost.
- cpu_rd=cpu_wr=1 at addr 0x10: mem_we=1, mem_oe=0; cpu_q unchanged.
- Reset asserted in WAIT of a DMA read: mem_oe/mem_we=0 next cycle, no dma_ack; after reset release with dma_req still high, the access restarts and dma_ack pulses once.
- dma_req deasserted one cycle after grant: dma_ack still pulses at LAT; the next slot is idle if no CPU request.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one SDRAM CPU port between the motherboard CPU and a DMA/loader port
// CPU has fixed priority; a starvation counter forces a DMA slot after STARVE back-to-back CPU wins.
module sdram_port_arbiter #(
  parameter int AW     = 23,
  parameter int LAT    = 6,
  parameter int STARVE = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_ref,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_q,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic [7:0]    dma_q,
  output logic          dma_ack,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          busy
);
  localparam logic [3:0] LAT_LAST   = 4'(LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_lat_cnt;
  logic [3:0]      r_starve_cnt;
  logic            r_is_dma;
  logic            r_is_wr;
  logic            r_mem_oe;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [7:0]      r_mem_din;
  logic [7:0]      r_cpu_q;
  logic [7:0]      r_dma_q;
  logic            r_cpu_ack;
  logic            r_dma_ack;

  logic            w_cpu_req;
  logic            w_grant_cpu;
  logic            w_grant_dma;
  logic            w_grant_wr;

  assign w_cpu_req   = cpu_rd | cpu_wr;
  assign w_grant_cpu = (r_state == S_IDLE) && ce_ref && w_cpu_req &&
                       !(dma_req && (r_starve_cnt == STARVE_MAX));
  assign w_grant_dma = (r_state == S_IDLE) && ce_ref && !w_grant_cpu && dma_req;
  // rd+wr together from the CPU resolves to a write
  assign w_grant_wr  = w_grant_cpu ? cpu_wr : dma_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_cpu || w_grant_dma) w_next = S_ISSUE;
      S_ISSUE: if (ce_ref) w_next = S_WAIT;
      S_WAIT:  if (r_lat_cnt == LAT_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_is_dma     <= 1'b0;
      r_is_wr      <= 1'b0;
      r_mem_oe     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_cpu_q      <= '0;
      r_dma_q      <= '0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_lat_cnt <= '0;
          if (w_grant_cpu || w_grant_dma) begin
            r_is_dma   <= w_grant_dma;
            r_is_wr    <= w_grant_wr;
            r_mem_addr <= w_grant_cpu ? cpu_addr : dma_addr;
            r_mem_din  <= w_grant_cpu ? cpu_din : dma_din;
            r_mem_we   <= w_grant_wr;
            r_mem_oe   <= !w_grant_wr;
          end
          if (w_grant_cpu && dma_req) begin
            if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 4'd1;
          end else if (w_grant_cpu || w_grant_dma) begin
            r_starve_cnt <= '0;
          end
        end
        S_ISSUE, S_WAIT: begin
          // latency counts from ISSUE entry and holds once reached, however long ISSUE lasts
          if (r_lat_cnt != LAT_LAST) r_lat_cnt <= r_lat_cnt + 4'd1;
          if ((r_state == S_ISSUE) && ce_ref) begin
            r_mem_oe <= 1'b0;
            r_mem_we <= 1'b0;
          end
          if (w_next == S_DONE) begin
            r_cpu_ack <= !r_is_dma;
            r_dma_ack <= r_is_dma;
            if (!r_is_wr) begin
              if (r_is_dma) r_dma_q <= mem_dout;
              else          r_cpu_q <= mem_dout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_oe   = r_mem_oe;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign cpu_q    = r_cpu_q;
  assign dma_q    = r_dma_q;
  assign cpu_ack  = r_cpu_ack;
  assign dma_ack  = r_dma_ack;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
// A slot-timing model predicts every output each cycle; directed tests add literal expectations.
module tb_sdram_port_arbiter;
  localparam int AW = 23, LAT = 6, STARVE = 4;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ce_ref = 1'b0;
  logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic [7:0]    cpu_q;
  logic          cpu_ack;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_din = '0;
  logic [7:0]    dma_q;
  logic          dma_ack;
  logic          mem_oe, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = '0;
  logic          busy;

  sdram_port_arbiter #(.AW(AW), .LAT(LAT), .STARVE(STARVE)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_q(cpu_q), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_q(dma_q), .dma_ack(dma_ack),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ce_ref: one pulse every 4th cycle
  int ce_k = 0;
  initial begin
    forever begin
      @(posedge clk_sys); #1;
      ce_ref = (ce_k % 4 == 3);
      ce_k++;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a granted access issues at E; its command lasts through the first ce_ref cycle c >= E;
  // the ack lands at max(c+2, E+LAT).
  bit            m_valid = 0, m_active = 0, m_ck = 0, m_dma = 0, m_wr = 0;
  int            m_e = 0, m_done = 0, m_starve = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_din = '0, m_cpu_q = '0, m_dma_q = '0;

  int    cmd_start = 0, n_cpu_ack = 0, n_dma_ack = 0;
  bit    prev_cmd = 0, seen_oe = 0, seen_we = 0;
  logic [AW-1:0] we_addr = '0;
  logic [7:0]    we_din = '0;
  string ack_log = "";

  always @(negedge clk_sys) begin
    bit e_cmd;
    if (m_valid) begin
      e_cmd = m_active && (cyc >= m_e) && !m_ck;
      chk("mem_oe", 32'(mem_oe), 32'(e_cmd && !m_wr));
      chk("mem_we", 32'(mem_we), 32'(e_cmd && m_wr));
      if (e_cmd) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_din", 32'(mem_din), 32'(m_din));
      end
      chk("busy", 32'(busy), 32'(m_active && (cyc >= m_e)));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_active && m_ck && (cyc == m_done) && !m_dma));
      chk("dma_ack", 32'(dma_ack), 32'(m_active && m_ck && (cyc == m_done) && m_dma));
      chk("cpu_q", 32'(cpu_q), 32'(m_cpu_q));
      chk("dma_q", 32'(dma_q), 32'(m_dma_q));
      if ((mem_oe || mem_we) && !prev_cmd) cmd_start = cyc;
      prev_cmd = mem_oe || mem_we;
      if (mem_oe) seen_oe = 1;
      if (mem_we) begin seen_we = 1; we_addr = mem_addr; we_din = mem_din; end
      if (cpu_ack) begin n_cpu_ack++; ack_log = {ack_log, "C"}; end
      if (dma_ack) begin n_dma_ack++; ack_log = {ack_log, "D"}; end
    end
    if (reset) begin
      m_valid = 1; m_active = 0; m_ck = 0; m_starve = 0; m_cpu_q = '0; m_dma_q = '0;
    end else if (m_valid) begin
      if (m_active) begin
        if (!m_ck && (cyc >= m_e) && ce_ref) begin
          m_ck = 1;
          m_done = (cyc + 2 > m_e + LAT) ? cyc + 2 : m_e + LAT;
        end
        if (m_ck && (cyc + 1 == m_done) && !m_wr) begin
          if (m_dma) m_dma_q = mem_dout; else m_cpu_q = mem_dout;
        end
        if (m_ck && (cyc == m_done)) m_active = 0;
      end else if (ce_ref) begin
        if ((cpu_rd || cpu_wr) && !(dma_req && m_starve == STARVE)) begin
          m_starve = dma_req ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
          m_active = 1; m_ck = 0; m_e = cyc + 1;
          m_dma = 0; m_wr = cpu_wr; m_addr = cpu_addr; m_din = cpu_din;
        end else if (dma_req) begin
          m_starve = 0;
          m_active = 1; m_ck = 0; m_e = cyc + 1;
          m_dma = 1; m_wr = dma_we; m_addr = dma_addr; m_din = dma_din;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_ack(input bit want_dma, output int at);
    at = -1;
    for (int i = 0; i < 64 && at < 0; i++) begin
      @(negedge clk_sys); #1;
      if (want_dma ? dma_ack : cpu_ack) at = cyc;
    end
    if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int at, a0, ph, e_at;
    string exp_log;

    repeat (3) step();
    reset = 1'b0;
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_cpu_q", 32'(cpu_q), 32'd0);
    chk("rst_dma_q", 32'(dma_q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'({mem_oe, mem_we, cpu_ack, dma_ack}), 32'd0);

    // CPU read
    cpu_addr = 23'h000123; mem_dout = 8'h5A; cpu_rd = 1'b1;
    wait_ack(0, at);
    step(); cpu_rd = 1'b0;
    chk("cpu_rd_q", 32'(cpu_q), 32'h5A);
    chk("cpu_rd_latency", 32'(at - cmd_start), 32'd6);
    repeat (8) step();
    chk("cpu_rd_no_dma_ack", 32'(n_dma_ack), 32'd0);

    // DMA write at top address
    seen_oe = 0; seen_we = 0; a0 = n_dma_ack;
    dma_addr = 23'h7FFFFF; dma_din = 8'hC3; dma_we = 1'b1; dma_req = 1'b1;
    wait_ack(1, at);
    step(); dma_req = 1'b0; dma_we = 1'b0;
    repeat (8) step();
    chk("dma_wr_addr", 32'(we_addr), 32'h7FFFFF);
    chk("dma_wr_din", 32'(we_din), 32'hC3);
    chk("dma_wr_no_oe", 32'(seen_oe), 32'd0);
    chk("dma_wr_ack_once", 32'(n_dma_ack - a0), 32'd1);
    chk("dma_wr_q", 32'(dma_q), 32'd0);

    // CPU rd+wr together acts as a write
    seen_oe = 0; seen_we = 0;
    cpu_addr = 23'h10; cpu_din = 8'h77; mem_dout = 8'h99; cpu_rd = 1'b1; cpu_wr = 1'b1;
    wait_ack(0, at);
    step(); cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (4) step();
    chk("rdwr_we", 32'(seen_we), 32'd1);
    chk("rdwr_no_oe", 32'(seen_oe), 32'd0);
    chk("rdwr_addr", 32'(we_addr), 32'h10);
    chk("rdwr_q", 32'(cpu_q), 32'h5A);

    // Both requesting continuously: four CPU grants, then a forced DMA grant
    ack_log = ""; exp_log = "CCCCDCCCCD";
    cpu_addr = 23'h40; mem_dout = 8'h11; dma_addr = 23'h200; dma_we = 1'b0;
    cpu_rd = 1'b1; dma_req = 1'b1;
    a0 = n_cpu_ack + n_dma_ack;
    for (int i = 0; i < 200 && (n_cpu_ack + n_dma_ack - a0) < 10; i++) begin
      @(negedge clk_sys); #1;
    end
    step(); cpu_rd = 1'b0; dma_req = 1'b0;
    n_cmp++;
    if (ack_log != exp_log) begin
      n_bad++;
      $display("FAIL starve_order: got %s expected %s", ack_log, exp_log);
    end
    repeat (8) step();

    // Reset during WAIT of a DMA read
    dma_addr = 23'h2AA; dma_we = 1'b0; mem_dout = 8'h66; dma_req = 1'b1;
    ph = 0;
    for (int i = 0; i < 64 && ph < 2; i++) begin
      @(negedge clk_sys); #1;
      if (ph == 0 && mem_oe) ph = 1;
      else if (ph == 1 && !mem_oe) ph = 2;
    end
    if (ph < 2) chk("rst_wait_timeout", 32'd0, 32'd1);
    a0 = n_dma_ack;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    chk("midrst_cmd", 32'({mem_oe, mem_we}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dma_q", 32'(dma_q), 32'd0);
    @(negedge clk_sys); #1;
    chk("midrst_no_ack", 32'(n_dma_ack - a0), 32'd0);
    wait_ack(1, at);
    step(); dma_req = 1'b0;
    repeat (8) step();
    chk("midrst_restart_ack_once", 32'(n_dma_ack - a0), 32'd1);
    chk("midrst_restart_q", 32'(dma_q), 32'h66);

    // DMA request withdrawn right after grant
    dma_addr = 23'h55; mem_dout = 8'h3C; dma_req = 1'b1;
    e_at = -1;
    for (int i = 0; i < 64 && e_at < 0; i++) begin
      @(negedge clk_sys); #1;
      if (busy) e_at = cyc;
    end
    if (e_at < 0) chk("busy_timeout", 32'd0, 32'd1);
    step(); dma_req = 1'b0;
    wait_ack(1, at);
    chk("drop_ack_latency", 32'(at - e_at), 32'd6);
    chk("drop_q", 32'(dma_q), 32'h3C);
    seen_oe = 0; seen_we = 0;
    repeat (12) step();
    chk("drop_next_slot_idle", 32'({seen_oe, seen_we}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
